// File: rtl/data_sw_pipe.sv
// data_sw_pipe
// Converts a stream of sign-magnitude words into one of four number codes
// (pass, ones' complement, two's complement, offset binary) through a
// 2-stage valid/ready pipeline. The conversion mode is switched only after
// the pipeline has drained, so every word is converted with one mode.
//
// Optional feature macro: STAT_CNT_EN (adds saturating transfer counters).
//
// Parameters:
//   W        data width, MSB is the sign bit (W >= 2)
//   RST_MODE mode_cur value after reset (0..3)
//   CNT_W    statistics counter width (STAT_CNT_EN only)
//
// Ports:
//   clk, res           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake, in_data sign-magnitude word
//   mode_req[_valid]   run-time mode request strobe
//   mode_cur           mode applied to newly accepted words
//   out_valid/out_ready output handshake, out_data converted word
//   out_nz             current output came from negative zero
//   busy               FSM is draining or switching
//   conv_cnt, nz_cnt   output transfer / negative-zero counters (STAT_CNT_EN)
module data_sw_pipe #(
    parameter int W        = 8,
    parameter int RST_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       mode_req,
    input  logic             mode_req_valid,
    output logic [1:0]       mode_cur,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_nz,
    output logic             busy
`ifdef STAT_CNT_EN
    ,
    output logic [CNT_W-1:0] conv_cnt,
    output logic [CNT_W-1:0] nz_cnt
`endif
);

    localparam logic [1:0] RST_MODE_L = 2'(RST_MODE);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      pending, pending_nxt;

    logic            vld_p1;
    logic [W-1:0]    data_p1;
    logic [1:0]      mode_p1;

    logic            vld_p2;
    logic [W-1:0]    data_p2;
    logic            nz_p2;

    logic            advance;
    logic            load_p1;
    logic            accept;

    // Sign-magnitude to the selected code. Two's complement of a negative
    // word is the arithmetic negation of its magnitude, so negative zero
    // collapses to zero without a special case.
    function automatic logic [W-1:0] convert(input logic [W-1:0] d,
                                             input logic [1:0]   md);
        logic                sgn;
        logic signed [W-1:0] mag;
        logic signed [W-1:0] neg;
        logic [W-1:0]        ones;
        logic [W-1:0]        twos;
        sgn  = d[W-1];
        mag  = $signed({1'b0, d[W-2:0]});
        neg  = -mag;
        ones = {1'b1, ~d[W-2:0]};
        twos = sgn ? $unsigned(neg) : d;
        case (md)
            2'd0:    convert = d;
            2'd1:    convert = sgn ? ones : d;
            2'd2:    convert = twos;
            default: convert = twos ^ {1'b1, {(W-1){1'b0}}};
        endcase
    endfunction

    function automatic logic is_neg_zero(input logic [W-1:0] d);
        is_neg_zero = d[W-1] & (d[W-2:0] == '0);
    endfunction

    assign advance  = !vld_p2 || out_ready;
    // Stage 1 may also fill while stage 2 is stalled, as long as it is empty.
    assign load_p1  = advance || !vld_p1;
    assign in_ready = (state == RUN) && (!vld_p1 || !vld_p2 || out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_nz    = nz_p2;
    assign busy      = (state != RUN);

    // Stage 1: capture raw word and the mode in force at acceptance
    always_ff @(posedge clk) begin
        if (res) begin
            vld_p1 <= 1'b0;
        end else if (load_p1) begin
            vld_p1 <= accept;
        end
        if (load_p1 && accept) begin
            data_p1 <= in_data;
            mode_p1 <= mode_cur;
        end
    end

    // Stage 2: converted word and negative-zero flag
    always_ff @(posedge clk) begin
        if (res) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            nz_p2   <= 1'b0;
        end else if (advance) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= convert(data_p1, mode_p1);
                nz_p2   <= is_neg_zero(data_p1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= RUN;
            pending  <= RST_MODE_L;
            mode_cur <= RST_MODE_L;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (state == SWITCH) begin
                mode_cur <= pending;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            RUN: begin
                if (mode_req_valid && (mode_req != mode_cur)) begin
                    pending_nxt = mode_req;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                // Later requests overwrite earlier ones while draining.
                if (mode_req_valid) begin
                    pending_nxt = mode_req;
                end
                if (!vld_p1 && !vld_p2) begin
                    state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

`ifdef STAT_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (res) begin
            conv_cnt <= '0;
            nz_cnt   <= '0;
        end else if (vld_p2 && out_ready) begin
            conv_cnt <= sat_inc(conv_cnt);
            if (nz_p2) begin
                nz_cnt <= sat_inc(nz_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_sw_pipe.sv
// Directed testbench for data_sw_pipe (W=8, RST_MODE=0). A negedge monitor
// pushes expected words into a scoreboard queue on every input transfer and
// pops/compares them on every output transfer.
module tb_data_sw_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         res;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   mode_req;
    logic         mode_req_valid;
    logic [1:0]   mode_cur;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_nz;
    logic         busy;
`ifdef STAT_CNT_EN
    logic [15:0]  conv_cnt;
    logic [15:0]  nz_cnt;
`endif

    int           total  = 0;
    int           passed = 0;
    int           fails  = 0;
    logic [1:0]   model_mode;
    logic [8:0]   sb[$];

    data_sw_pipe #(.W(W), .RST_MODE(0), .CNT_W(16)) dut (
        .clk            (clk),
        .res            (res),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_cur       (mode_cur),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_nz         (out_nz),
        .busy           (busy)
`ifdef STAT_CNT_EN
        ,
        .conv_cnt       (conv_cnt),
        .nz_cnt         (nz_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference conversion: {nz, result}
    function automatic logic [8:0] model(input logic [7:0] d, input logic [1:0] md);
        int         mag;
        logic [7:0] r;
        logic [7:0] neg;
        logic       nz;
        mag = int'(d[6:0]);
        nz  = d[7] && (mag == 0);
        neg = d[7] ? 8'((256 - mag) % 256) : d;
        case (md)
            2'd0:    r = d;
            2'd1:    r = d[7] ? (8'hFF - 8'(mag)) : d;
            2'd2:    r = neg;
            default: r = neg ^ 8'h80;
        endcase
        return {nz, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!res) begin
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, model_mode));
            end
            if (out_valid && out_ready) begin
                total++;
                assert (sb.size() != 0) passed++;
                else begin
                    fails++;
                    $error("FAIL out_unexpected: got %0h want none", {out_nz, out_data});
                end
                if (sb.size() != 0) begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("out_word", 32'({out_nz, out_data}), 32'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int g;
        in_valid = 1'b1;
        in_data  = d;
        g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        chk("send_bound", 32'(g < 100), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((busy || sb.size() != 0) && g < 200) begin
            tick();
            g++;
        end
        chk("drain_bound", 32'(g < 200), 32'd1);
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode_req       = m;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        model_mode     = m;
        drain();
        chk("mode_cur", 32'(mode_cur), 32'(m));
    endtask

    initial begin
        int         acc;
        int         g;
        logic       a;
        logic [7:0] held;

        res            = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        mode_req       = 2'd0;
        mode_req_valid = 1'b0;
        out_ready      = 1'b1;
        model_mode     = 2'd0;
        repeat (3) tick();
        res = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_nz",    32'(out_nz),    32'd0);
        chk("rst_mode_cur",  32'(mode_cur),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // mode 0, two back-to-back words, 2-cycle latency
        in_valid = 1'b1;
        in_data  = 8'h85;
        tick();
        chk("lat_valid_c1", 32'(out_valid), 32'd0);
        in_data = 8'h05;
        tick();
        in_valid = 1'b0;
        chk("lat_valid_c2", 32'(out_valid), 32'd1);
        chk("lat_data_c2",  32'(out_data),  32'h85);
        tick();
        chk("thru_valid_c3", 32'(out_valid), 32'd1);
        chk("thru_data_c3",  32'(out_data),  32'h05);
        tick();
        chk("thru_valid_c4", 32'(out_valid), 32'd0);
        drain();

        set_mode(2'd1);
        send(8'h85);
        send(8'h7F);
        drain();

        set_mode(2'd2);
        send(8'h85);
        send(8'h80);
        send(8'h05);
        drain();

        set_mode(2'd3);
        send(8'h85);
        send(8'h05);
        send(8'h00);
        drain();

        // backpressure: out_ready low for 5 cycles with continuous in_valid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        acc = 0;
        repeat (5) begin
            a = in_ready;
            tick();
            if (a) begin
                acc++;
                in_data = in_data + 8'd1;
            end
        end
        chk("bp_accepted", 32'(acc),       32'd2);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_valid",    32'(out_valid), 32'd1);
        chk("bp_data",     32'(out_data),  32'h91);
        held = out_data;
        in_valid = 1'b0;
        tick();
        chk("bp_hold", 32'(out_data), 32'(held));
        out_ready = 1'b1;
        send(8'h13);
        send(8'h14);
        drain();

        // request in the same cycle as an accepted word
        set_mode(2'd2);
        in_valid       = 1'b1;
        in_data        = 8'h85;
        mode_req       = 2'd1;
        mode_req_valid = 1'b1;
        chk("req_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid       = 1'b0;
        mode_req_valid = 1'b0;
        model_mode     = 2'd1;
        g = 0;
        while (busy && g < 50) begin
            chk("drain_in_ready", 32'(in_ready), 32'd0);
            g++;
            tick();
        end
        chk("busy_cycles", 32'(g), 32'd4);
        chk("switched_mode", 32'(mode_cur), 32'd1);
        send(8'h85);
        drain();

        // second request during DRAIN wins
        in_valid       = 1'b1;
        in_data        = 8'h85;
        mode_req       = 2'd2;
        mode_req_valid = 1'b1;
        tick();
        in_valid   = 1'b0;
        mode_req   = 2'd3;
        model_mode = 2'd3;
        tick();
        mode_req_valid = 1'b0;
        drain();
        chk("last_wins_mode", 32'(mode_cur), 32'd3);
        send(8'h85);
        drain();

        // reset with two words in flight and a drain pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h21;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        mode_req       = 2'd0;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        res = 1'b1;
        tick();
        res = 1'b0;
        sb.delete();
        model_mode = 2'd0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data",  32'(out_data),  32'd0);
        chk("mid_rst_mode_cur",  32'(mode_cur),  32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
`ifdef STAT_CNT_EN
        chk("mid_rst_conv_cnt",  32'(conv_cnt),  32'd0);
        chk("mid_rst_nz_cnt",    32'(nz_cnt),    32'd0);
`endif
        out_ready = 1'b1;
        repeat (4) begin
            tick();
            chk("no_stale_out", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
